// File: rtl/main_mem_slave_pkg.sv
// rtl/main_mem_slave_pkg.sv - shared defaults and FSM encodings for main_mem_slave
//
// Purpose: block geometry and latency defaults, read/write state encodings,
//          and a counter-width helper used by the top module.
// Ports:   none (package).

package main_mem_slave_pkg;

   localparam int BLK_LEN_DEF   = 4;
   localparam int BLK_SIZE_DEF  = BLK_LEN_DEF * 32;
   localparam int READ_LAT_DEF  = 8;
   localparam int WRITE_LAT_DEF = 4;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_WAIT = 1'b1
   } w_state_t;

   // Bits needed to hold a latency counter preloaded with lat-1.
   function automatic int cnt_w(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/main_mem_array.sv
// rtl/main_mem_array.sv - word-organised storage with byte-enabled write and block read
//
// Purpose: 2^ADDR_W x 32-bit register array. Contents are not reset.
// Ports:
//   cpu_clk        clock
//   we             commit strobe for the write port
//   waddr, wbe     word index and byte enables of the write
//   wdata          write data
//   raddr          word index of the read; the block base is derived here
//   rblk           BLK_LEN words starting at the aligned block base (combinational)

module main_mem_array #(
   parameter int ADDR_W  = 12,
   parameter int BLK_LEN = 4
) (
   input  logic                    cpu_clk,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [3:0]              wbe,
   input  logic [31:0]             wdata,
   input  logic [ADDR_W-1:0]       raddr,
   output logic [BLK_LEN*32-1:0]   rblk
);

   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] rbase;

   always_ff @(posedge cpu_clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rbase = raddr & ~ADDR_W'(BLK_LEN - 1);

   // Combinational read: a same-edge write is not yet visible, so a capture
   // on the commit edge sees the pre-write word.
   always_comb begin
      rblk = '0;
      for (int i = 0; i < BLK_LEN; i++) begin
         rblk[32*i +: 32] = mem[rbase | ADDR_W'(i)];
      end
   end

endmodule

// File: rtl/main_mem_slave.sv
// rtl/main_mem_slave.sv - fixed-latency main-memory responder for cache read/write buses
//
// Purpose: accepts one read and one write at a time, independently; returns
//          read data after READ_LAT cycles and write completion after WRITE_LAT.
// Build option: MAIN_MEM_BLOCK_READ_EN returns the whole aligned block on
//          dev_rdata; otherwise only the addressed word in dev_rdata[31:0].
// Ports:
//   cpu_clk, cpu_rst                   clock, async active-high reset
//   dev_wrdy                           write channel idle
//   dev_wen, dev_waddr, dev_wdata      write request (nonzero wen = request)
//   dev_rrdy                           read channel idle
//   dev_ren, dev_raddr                 read request (nonzero ren = request)
//   dev_rvalid, dev_rdata              one-cycle read response and held data

module main_mem_slave
   import main_mem_slave_pkg::*;
#(
   parameter int BLK_LEN   = BLK_LEN_DEF,
   parameter int ADDR_W    = 12,
   parameter int READ_LAT  = READ_LAT_DEF,
   parameter int WRITE_LAT = WRITE_LAT_DEF
) (
   input  logic                    cpu_clk,
   input  logic                    cpu_rst,
   output logic                    dev_wrdy,
   input  logic [3:0]              dev_wen,
   input  logic [31:0]             dev_waddr,
   input  logic [31:0]             dev_wdata,
   output logic                    dev_rrdy,
   input  logic [3:0]              dev_ren,
   input  logic [31:0]             dev_raddr,
   output logic                    dev_rvalid,
   output logic [BLK_LEN*32-1:0]   dev_rdata
);

   localparam int BLK_SIZE = BLK_LEN * 32;
   localparam int RCW      = cnt_w(READ_LAT);
   localparam int WCW      = cnt_w(WRITE_LAT);

   r_state_t          r_state;
   logic [RCW-1:0]    r_cnt;
   logic [ADDR_W-1:0] r_idx;

   w_state_t          w_state;
   logic [WCW-1:0]    w_cnt;
   logic [ADDR_W-1:0] w_idx;
   logic [31:0]       w_data;
   logic [3:0]        w_be;

   logic                mem_we;
   logic [BLK_SIZE-1:0] rblk;
   logic [BLK_SIZE-1:0] cap_data;

   // Byte offset and address bits above the array are aliased away.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, dev_waddr[31:ADDR_W+2], dev_waddr[1:0],
                               dev_raddr[31:ADDR_W+2], dev_raddr[1:0]};

   assign mem_we = (w_state == W_WAIT) && (w_cnt == '0);

   main_mem_array #(
      .ADDR_W  (ADDR_W),
      .BLK_LEN (BLK_LEN)
   ) u_array (
      .cpu_clk (cpu_clk),
      .we      (mem_we),
      .waddr   (w_idx),
      .wbe     (w_be),
      .wdata   (w_data),
      .raddr   (r_idx),
      .rblk    (rblk)
   );

`ifdef MAIN_MEM_BLOCK_READ_EN
   assign cap_data = rblk;
`else
   localparam int OFF_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

   logic [OFF_W-1:0] r_off;
   logic [31:0]      rd_word;

   assign r_off = (BLK_LEN > 1) ? r_idx[OFF_W-1:0] : '0;

   always_comb begin
      rd_word = rblk[31:0];
      for (int i = 0; i < BLK_LEN; i++) begin
         if (OFF_W'(i) == r_off) begin
            rd_word = rblk[32*i +: 32];
         end
      end
   end

   always_comb begin
      cap_data       = '0;
      cap_data[31:0] = rd_word;
   end
`endif

   // Read channel: idle -> count READ_LAT edges -> one response cycle.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_state    <= R_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         dev_rrdy   <= 1'b1;
         dev_rvalid <= 1'b0;
         dev_rdata  <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (|dev_ren) begin
                  r_state  <= R_WAIT;
                  r_idx    <= dev_raddr[ADDR_W+1:2];
                  r_cnt    <= RCW'(READ_LAT - 1);
                  dev_rrdy <= 1'b0;
               end
            end
            R_WAIT: begin
               if (r_cnt == '0) begin
                  r_state    <= R_RESP;
                  dev_rdata  <= cap_data;
                  dev_rvalid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - RCW'(1);
               end
            end
            R_RESP: begin
               r_state    <= R_IDLE;
               dev_rvalid <= 1'b0;
               dev_rrdy   <= 1'b1;
            end
            default: begin
               r_state    <= R_IDLE;
               dev_rvalid <= 1'b0;
               dev_rrdy   <= 1'b1;
            end
         endcase
      end
   end

   // Write channel: latch request, commit on the edge the counter hits zero.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         w_state  <= W_IDLE;
         w_cnt    <= '0;
         w_idx    <= '0;
         w_data   <= '0;
         w_be     <= '0;
         dev_wrdy <= 1'b1;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (|dev_wen) begin
                  w_state  <= W_WAIT;
                  w_idx    <= dev_waddr[ADDR_W+1:2];
                  w_data   <= dev_wdata;
                  w_be     <= dev_wen;
                  w_cnt    <= WCW'(WRITE_LAT - 1);
                  dev_wrdy <= 1'b0;
               end
            end
            W_WAIT: begin
               if (w_cnt == '0) begin
                  w_state  <= W_IDLE;
                  dev_wrdy <= 1'b1;
               end else begin
                  w_cnt <= w_cnt - WCW'(1);
               end
            end
            default: begin
               w_state  <= W_IDLE;
               dev_wrdy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_main_mem_slave.sv
// tb/tb_main_mem_slave.sv - directed self-checking bench for main_mem_slave

module tb_main_mem_slave;

   logic         cpu_clk = 1'b0;
   logic         cpu_rst;
   logic         dev_wrdy;
   logic [3:0]   dev_wen;
   logic [31:0]  dev_waddr;
   logic [31:0]  dev_wdata;
   logic         dev_rrdy;
   logic [3:0]   dev_ren;
   logic [31:0]  dev_raddr;
   logic         dev_rvalid;
   logic [127:0] dev_rdata;

   int checks   = 0;
   int failures = 0;
   int rv_count = 0;

   main_mem_slave dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .dev_wrdy   (dev_wrdy),
      .dev_wen    (dev_wen),
      .dev_waddr  (dev_waddr),
      .dev_wdata  (dev_wdata),
      .dev_rrdy   (dev_rrdy),
      .dev_ren    (dev_ren),
      .dev_raddr  (dev_raddr),
      .dev_rvalid (dev_rvalid),
      .dev_rdata  (dev_rdata)
   );

   always #5 cpu_clk = ~cpu_clk;

   always @(negedge cpu_clk) begin
      if (dev_rvalid === 1'b1) rv_count <= rv_count + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected response given the four words of the block and the addressed slot.
   function automatic logic [127:0] exp_blk(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3,
                                             input int sel);
      logic [31:0] w;
      case (sel)
         0:       w = w0;
         1:       w = w1;
         2:       w = w2;
         default: w = w3;
      endcase
`ifdef MAIN_MEM_BLOCK_READ_EN
      return {w3, w2, w1, w0} | {96'b0, w & 32'h0} ;
`else
      return {96'b0, w};
`endif
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input string tag);
      int n;
      @(negedge cpu_clk);
      dev_waddr = a;
      dev_wdata = d;
      dev_wen   = be;
      @(negedge cpu_clk);
      dev_wen = 4'h0;
      n = 0;
      while (dev_wrdy !== 1'b1 && n < 50) begin
         n++;
         @(negedge cpu_clk);
      end
      check({tag, " wrdy_low_cycles"}, n, 4);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [127:0] d, input string tag);
      int n;
      @(negedge cpu_clk);
      dev_raddr = a;
      dev_ren   = 4'hF;
      @(negedge cpu_clk);
      dev_ren = 4'h0;
      n = 0;
      while (dev_rvalid !== 1'b1 && n < 50) begin
         @(negedge cpu_clk);
         n++;
      end
      check({tag, " rvalid_latency"}, n, 8);
      check({tag, " rrdy_during_resp"}, dev_rrdy, 0);
      d = dev_rdata;
      @(negedge cpu_clk);
      check({tag, " rvalid_one_cycle"}, dev_rvalid, 0);
      check({tag, " rrdy_back"}, dev_rrdy, 1);
   endtask

   initial begin
      logic [127:0] rd;
      int c0;
      int n;

      cpu_rst   = 1'b1;
      dev_wen   = 4'h0;
      dev_waddr = 32'h0;
      dev_wdata = 32'h0;
      dev_ren   = 4'h0;
      dev_raddr = 32'h0;

      repeat (3) @(posedge cpu_clk);
      #1;
      check("reset rrdy", dev_rrdy, 1);
      check("reset wrdy", dev_wrdy, 1);
      check("reset rvalid", dev_rvalid, 0);
      check("reset rdata", dev_rdata, 128'h0);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;

      // Known contents for the block at 0x100.
      do_write(32'h100, 32'h0000_0000, 4'hF, "init0");
      do_write(32'h104, 32'h2222_2222, 4'hF, "init1");
      do_write(32'h108, 32'h3333_3333, 4'hF, "init2");
      do_write(32'h10C, 32'h4444_4444, 4'hF, "init3");

      // Full-word write then block read.
      do_write(32'h100, 32'hDEAD_BEEF, 4'hF, "wr_full");
      do_read(32'h104, rd, "rd_104");
      check("rd_104 data", rd, exp_blk(32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1));
      do_read(32'h100, rd, "rd_100");
      check("rd_100 data", rd, exp_blk(32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0));

      // Byte merge: only byte 1 replaced.
      do_write(32'h100, 32'h0000_AB00, 4'h2, "wr_byte");
      do_read(32'h100, rd, "rd_merge");
      check("rd_merge data", rd, exp_blk(32'hDEAD_ABEF, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0));

      // Request while busy is dropped.
      c0 = rv_count;
      @(negedge cpu_clk);
      dev_raddr = 32'h100;
      dev_ren   = 4'hF;
      @(negedge cpu_clk);
      dev_ren = 4'h0;
      repeat (2) @(negedge cpu_clk);
      check("ignored rrdy_busy", dev_rrdy, 0);
      dev_raddr = 32'h110;
      dev_ren   = 4'hF;
      @(negedge cpu_clk);
      dev_ren = 4'h0;
      repeat (20) @(negedge cpu_clk);
      check("ignored pulse_count", rv_count - c0, 1);
      check("ignored data", dev_rdata, exp_blk(32'hDEAD_ABEF, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0));

      // Collision: write accepted 4 edges after the read so commit and capture share an edge.
      @(negedge cpu_clk);
      dev_raddr = 32'h10C;
      dev_ren   = 4'hF;
      @(negedge cpu_clk);
      dev_ren = 4'h0;
      repeat (3) @(negedge cpu_clk);
      dev_waddr = 32'h10C;
      dev_wdata = 32'h55AA_55AA;
      dev_wen   = 4'hF;
      @(negedge cpu_clk);
      dev_wen = 4'h0;
      n = 4;
      while (dev_rvalid !== 1'b1 && n < 50) begin
         @(negedge cpu_clk);
         n++;
      end
      check("collision latency", n, 8);
      check("collision wrdy_same_edge", dev_wrdy, 1);
      check("collision old_data", dev_rdata, exp_blk(32'hDEAD_ABEF, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 3));
      do_read(32'h10C, rd, "rd_after_collision");
      check("rd_after_collision data", rd, exp_blk(32'hDEAD_ABEF, 32'h2222_2222, 32'h3333_3333, 32'h55AA_55AA, 3));

      // Upper address bits alias; byte offset ignored.
      do_write(32'h4108, 32'hCAFE_F00D, 4'hF, "wr_alias");
      do_read(32'h10B, rd, "rd_alias");
      check("rd_alias data", rd, exp_blk(32'hDEAD_ABEF, 32'h2222_2222, 32'hCAFE_F00D, 32'h55AA_55AA, 2));

      // Reset 3 cycles after acceptance of a read and a write.
      c0 = rv_count;
      @(negedge cpu_clk);
      dev_raddr = 32'h100;
      dev_ren   = 4'hF;
      dev_waddr = 32'h100;
      dev_wdata = 32'h1234_5678;
      dev_wen   = 4'hF;
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      dev_ren = 4'h0;
      dev_wen = 4'h0;
      check("rst pre rrdy_busy", dev_rrdy, 0);
      check("rst pre wrdy_busy", dev_wrdy, 0);
      repeat (3) @(posedge cpu_clk);
      #2;
      cpu_rst = 1'b1;
      #1;
      check("rst rrdy", dev_rrdy, 1);
      check("rst wrdy", dev_wrdy, 1);
      check("rst rvalid", dev_rvalid, 0);
      check("rst rdata", dev_rdata, 128'h0);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      repeat (12) @(negedge cpu_clk);
      check("rst no_rvalid", rv_count - c0, 0);
      do_read(32'h100, rd, "rd_after_rst");
      check("rd_after_rst write_discarded", rd, exp_blk(32'hDEAD_ABEF, 32'h2222_2222, 32'hCAFE_F00D, 32'h55AA_55AA, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
